// File: rtl/scarv_cop_cprs_mp_if.sv
// scarv_cop_cprs_mp_if: register-file access bundle.
// Three read ports (ren/addr -> rdata), two byte-enabled write ports.
interface scarv_cop_cprs_mp_if #(
  parameter int XLEN = 32,
  parameter int AW   = 4
);
  localparam int NB = XLEN / 8;

  logic            crs1_ren;
  logic [AW-1:0]   crs1_addr;
  logic [XLEN-1:0] crs1_rdata;
  logic            crs2_ren;
  logic [AW-1:0]   crs2_addr;
  logic [XLEN-1:0] crs2_rdata;
  logic            crs3_ren;
  logic [AW-1:0]   crs3_addr;
  logic [XLEN-1:0] crs3_rdata;

  logic [NB-1:0]   crda_wen;
  logic [AW-1:0]   crda_addr;
  logic [XLEN-1:0] crda_wdata;
  logic [NB-1:0]   crdb_wen;
  logic [AW-1:0]   crdb_addr;
  logic [XLEN-1:0] crdb_wdata;

  modport master (
    output crs1_ren, crs1_addr,
    output crs2_ren, crs2_addr,
    output crs3_ren, crs3_addr,
    input  crs1_rdata, crs2_rdata, crs3_rdata,
    output crda_wen, crda_addr, crda_wdata,
    output crdb_wen, crdb_addr, crdb_wdata
  );

  modport slave (
    input  crs1_ren, crs1_addr,
    input  crs2_ren, crs2_addr,
    input  crs3_ren, crs3_addr,
    output crs1_rdata, crs2_rdata, crs3_rdata,
    input  crda_wen, crda_addr, crda_wdata,
    input  crdb_wen, crdb_addr, crdb_wdata
  );
endinterface

// File: rtl/scarv_cop_cprs_mp.sv
// scarv_cop_cprs_mp: multi-port COP register file with pending-write
// scoreboard and secure zeroise sequencer.
// Ports: g_clk, g_resetn (sync, active-low), g_clk_req; rf (slave bundle:
// 3 read, 2 write ports); sb_set/sb_addr -> busy; zero_req -> zero_busy,
// zero_done.
module scarv_cop_cprs_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 16,
  parameter int AW     = 4,
  parameter int BYPASS = 1
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  output logic              g_clk_req,
  scarv_cop_cprs_mp_if.slave rf,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_addr,
  output logic [NREGS-1:0]  busy,
  input  logic              zero_req,
  output logic              zero_busy,
  output logic              zero_done
);

  localparam int NB = XLEN / 8;
  localparam logic [AW:0] NR = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST = AW'(NREGS-1);

  typedef enum logic [1:0] {
    IDLE,
    WIPE,
    DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [AW-1:0]   cnt_q;
  logic [AW-1:0]   cnt_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic            idle;

  logic [NB-1:0]   wa;
  logic [NB-1:0]   wb;
  logic [AW-1:0]   aa;
  logic [AW-1:0]   ab;
  logic [XLEN-1:0] da;
  logic [XLEN-1:0] db;

  logic [2:0]      ren;
  logic [AW-1:0]   raddr [3];
  logic [XLEN-1:0] rdata [3];

  assign wa = rf.crda_wen;
  assign aa = rf.crda_addr;
  assign da = rf.crda_wdata;
  assign wb = rf.crdb_wen;
  assign ab = rf.crdb_addr;
  assign db = rf.crdb_wdata;

  assign ren = {rf.crs3_ren, rf.crs2_ren, rf.crs1_ren};
  assign raddr[0] = rf.crs1_addr;
  assign raddr[1] = rf.crs2_addr;
  assign raddr[2] = rf.crs3_addr;

  assign rf.crs1_rdata = rdata[0];
  assign rf.crs2_rdata = rdata[1];
  assign rf.crs3_rdata = rdata[2];

  assign idle      = (state_q == IDLE);
  assign zero_busy = !idle;
  assign zero_done = (state_q == DONE);
  assign busy      = busy_q;

  assign g_clk_req = (|wa) | (|wb) | sb_set
                   | zero_req | !idle;

  // Zeroise sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (zero_req) begin
          state_d = WIPE;
          cnt_d   = '0;
        end
      end
      WIPE: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register update: B applied first so A overwrites shared lanes.
  // Addresses past NREGS never match any index and so drop out.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (idle) begin
        for (int b = 0; b < NB; b++) begin
          if (wb[b] && ab == AW'(i)) begin
            regs_d[i][8*b +: 8] = db[8*b +: 8];
          end
          if (wa[b] && aa == AW'(i)) begin
            regs_d[i][8*b +: 8] = da[8*b +: 8];
          end
        end
      end
      if (state_q == WIPE && cnt_q == AW'(i)) begin
        regs_d[i] = '0;
      end
    end
  end

  // Scoreboard: set beats clear; DONE wipes every flag.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++) begin
      if (idle) begin
        if ((|wa && aa == AW'(i)) ||
            (|wb && ab == AW'(i))) begin
          busy_d[i] = 1'b0;
        end
        if (sb_set && sb_addr == AW'(i)) begin
          busy_d[i] = 1'b1;
        end
      end
    end
    if (state_q == DONE) begin
      busy_d = '0;
    end
  end

  // Read ports, gated to zero while wiping so no residue leaks out.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rdata[p] = '0;
      if (ren[p] && idle && ({1'b0, raddr[p]} < NR)) begin
        for (int i = 0; i < NREGS; i++) begin
          if (raddr[p] == AW'(i)) begin
            rdata[p] = regs_q[i];
          end
        end
        if (BYPASS != 0) begin
          for (int b = 0; b < NB; b++) begin
            if (wb[b] && ab == raddr[p]) begin
              rdata[p][8*b +: 8] = db[8*b +: 8];
            end
            if (wa[b] && aa == raddr[p]) begin
              rdata[p][8*b +: 8] = da[8*b +: 8];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_scarv_cop_cprs_mp.sv
// tb_scarv_cop_cprs_mp: directed bench for scarv_cop_cprs_mp.
// Drives three instances (default, BYPASS=0, NREGS=12) in lockstep.
module tb_scarv_cop_cprs_mp;

  logic g_clk = 1'b0;
  logic g_resetn = 1'b0;
  always #5 g_clk = ~g_clk;

  logic        ren1, ren2, ren3;
  logic [3:0]  ra1, ra2, ra3;
  logic [3:0]  wa, wb, aa, ab;
  logic [31:0] da, db;
  logic        sb_set;
  logic [3:0]  sb_addr;
  logic        zero_req;

  logic        ck0, ck1, ck2;
  logic [15:0] busy0, busy1;
  logic [11:0] busy2;
  logic        zb0, zb1, zb2;
  logic        zd0, zd1, zd2;

  int n_chk = 0;
  int n_fail = 0;

  scarv_cop_cprs_mp_if #(.XLEN(32), .AW(4)) ifs [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_drv
    assign ifs[g].crs1_ren   = ren1;
    assign ifs[g].crs1_addr  = ra1;
    assign ifs[g].crs2_ren   = ren2;
    assign ifs[g].crs2_addr  = ra2;
    assign ifs[g].crs3_ren   = ren3;
    assign ifs[g].crs3_addr  = ra3;
    assign ifs[g].crda_wen   = wa;
    assign ifs[g].crda_addr  = aa;
    assign ifs[g].crda_wdata = da;
    assign ifs[g].crdb_wen   = wb;
    assign ifs[g].crdb_addr  = ab;
    assign ifs[g].crdb_wdata = db;
  end

  scarv_cop_cprs_mp #(
    .XLEN(32), .NREGS(16), .AW(4), .BYPASS(1)
  ) u0 (
    .g_clk(g_clk), .g_resetn(g_resetn), .g_clk_req(ck0),
    .rf(ifs[0]), .sb_set(sb_set), .sb_addr(sb_addr),
    .busy(busy0), .zero_req(zero_req),
    .zero_busy(zb0), .zero_done(zd0)
  );

  scarv_cop_cprs_mp #(
    .XLEN(32), .NREGS(16), .AW(4), .BYPASS(0)
  ) u1 (
    .g_clk(g_clk), .g_resetn(g_resetn), .g_clk_req(ck1),
    .rf(ifs[1]), .sb_set(sb_set), .sb_addr(sb_addr),
    .busy(busy1), .zero_req(zero_req),
    .zero_busy(zb1), .zero_done(zd1)
  );

  scarv_cop_cprs_mp #(
    .XLEN(32), .NREGS(12), .AW(4), .BYPASS(1)
  ) u2 (
    .g_clk(g_clk), .g_resetn(g_resetn), .g_clk_req(ck2),
    .rf(ifs[2]), .sb_set(sb_set), .sb_addr(sb_addr),
    .busy(busy2), .zero_req(zero_req),
    .zero_busy(zb2), .zero_done(zd2)
  );

  typedef struct {
    logic [3:0]  wa;
    logic [3:0]  aa;
    logic [31:0] da;
    logic [3:0]  wb;
    logic [3:0]  ab;
    logic [31:0] db;
    logic        sb;
    logic [3:0]  sa;
    logic        ren1;
    logic [3:0]  r1;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] e2nb;
    logic [31:0] e3;
    logic [15:0] ebusy;
  } vec_t;

  vec_t tv [11];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic idle_in();
    wa = '0; aa = '0; da = '0;
    wb = '0; ab = '0; db = '0;
    sb_set = 1'b0; sb_addr = '0;
    zero_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbusy, ndone, done_at, bad, nz, nzb;
    logic [31:0] r5;

    // v: wa aa da wb ab db sb sa ren1 r1 e1 e2 e2nb e3 busy
    tv[0]  = '{4'h0, 4'd0, 32'h0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0,
               1'b1, 4'd3, 32'h0, 32'h0, 32'h0, 32'h0, 16'h0};
    tv[1]  = '{4'hF, 4'd3, 32'h11223344, 4'h0, 4'd0, 32'h0,
               1'b0, 4'd0, 1'b1, 4'd3, 32'h11223344, 32'h0,
               32'h0, 32'h11223344, 16'h0};
    tv[2]  = '{4'h5, 4'd3, 32'hAABBCCDD, 4'h0, 4'd0, 32'h0,
               1'b0, 4'd0, 1'b1, 4'd3, 32'h11BB33DD, 32'h0,
               32'h0, 32'h11BB33DD, 16'h0};
    tv[3]  = '{4'h0, 4'd0, 32'h0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0,
               1'b1, 4'd3, 32'h11BB33DD, 32'h0, 32'h0,
               32'h11BB33DD, 16'h0};
    tv[4]  = '{4'h3, 4'd5, 32'h000000FF, 4'hF, 4'd5, 32'h12345678,
               1'b0, 4'd0, 1'b0, 4'd3, 32'h0, 32'h123400FF,
               32'h0, 32'h11BB33DD, 16'h0};
    tv[5]  = '{4'h0, 4'd0, 32'h0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0,
               1'b1, 4'd5, 32'h123400FF, 32'h123400FF,
               32'h123400FF, 32'h11BB33DD, 16'h0};
    tv[6]  = '{4'h0, 4'd0, 32'h0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd7,
               1'b1, 4'd7, 32'h0, 32'h123400FF, 32'h123400FF,
               32'h11BB33DD, 16'h0};
    tv[7]  = '{4'h0, 4'd7, 32'hFFFFFFFF, 4'h0, 4'd0, 32'h0,
               1'b0, 4'd0, 1'b1, 4'd7, 32'h0, 32'h123400FF,
               32'h123400FF, 32'h11BB33DD, 16'h0080};
    tv[8]  = '{4'h8, 4'd7, 32'hCAFEBABE, 4'h0, 4'd0, 32'h0,
               1'b0, 4'd0, 1'b1, 4'd7, 32'hCA000000, 32'h123400FF,
               32'h123400FF, 32'h11BB33DD, 16'h0080};
    tv[9]  = '{4'h0, 4'd0, 32'h0, 4'h1, 4'd7, 32'h00000011,
               1'b1, 4'd7, 1'b1, 4'd7, 32'hCA000011, 32'h123400FF,
               32'h123400FF, 32'h11BB33DD, 16'h0000};
    tv[10] = '{4'h0, 4'd0, 32'h0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0,
               1'b1, 4'd7, 32'hCA000011, 32'h123400FF,
               32'h123400FF, 32'h11BB33DD, 16'h0080};

    idle_in();
    ren1 = 1'b0; ra1 = '0;
    ren2 = 1'b1; ra2 = 4'd5;
    ren3 = 1'b1; ra3 = 4'd3;
    g_resetn = 1'b0;
    repeat (3) @(posedge g_clk);
    #1 g_resetn = 1'b1;

    @(negedge g_clk);
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_zero_busy", 32'(zb0), 32'h0);
    chk("rst_zero_done", 32'(zd0), 32'h0);
    chk("rst_clk_req", 32'(ck0), 32'h0);
    @(posedge g_clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      wa = tv[i].wa; aa = tv[i].aa; da = tv[i].da;
      wb = tv[i].wb; ab = tv[i].ab; db = tv[i].db;
      sb_set = tv[i].sb; sb_addr = tv[i].sa;
      ren1 = tv[i].ren1; ra1 = tv[i].r1;
      @(negedge g_clk);
      chk($sformatf("v%0d_rd1", i), ifs[0].crs1_rdata, tv[i].e1);
      chk($sformatf("v%0d_rd2", i), ifs[0].crs2_rdata, tv[i].e2);
      chk($sformatf("v%0d_rd2_nobyp", i),
          ifs[1].crs2_rdata, tv[i].e2nb);
      chk($sformatf("v%0d_rd3", i), ifs[0].crs3_rdata, tv[i].e3);
      chk($sformatf("v%0d_busy", i), 32'(busy0),
          32'(tv[i].ebusy));
      chk($sformatf("v%0d_clk_req", i), 32'(ck0),
          32'((|tv[i].wa) | (|tv[i].wb) | tv[i].sb));
      @(posedge g_clk);
      #1;
    end

    // Out-of-range access on the 12-register instance
    idle_in();
    wa = 4'hF; aa = 4'd13; da = 32'hDEADBEEF;
    sb_set = 1'b1; sb_addr = 4'd13;
    ren1 = 1'b1; ra1 = 4'd13;
    ra2 = 4'd1; ra3 = 4'd5;
    @(negedge g_clk);
    chk("oor_rd_same_cycle", ifs[2].crs1_rdata, 32'h0);
    @(posedge g_clk);
    #1 idle_in();
    @(negedge g_clk);
    chk("oor_busy", 32'(busy2), 32'h080);
    chk("oor_rd13", ifs[2].crs1_rdata, 32'h0);
    chk("oor_alias1", ifs[2].crs2_rdata, 32'h0);
    chk("oor_alias5", ifs[2].crs3_rdata, 32'h123400FF);
    chk("inrange_busy13", 32'(busy0), 32'h2080);
    @(posedge g_clk);
    #1;

    // Zeroise: load every register, flag reg 2 pending
    for (int i = 0; i < 16; i++) begin
      wa = 4'hF; aa = 4'(i);
      da = {4{8'(i + 1)}};
      sb_set = (i == 15); sb_addr = 4'd2;
      @(posedge g_clk);
      #1;
    end
    idle_in();
    ra1 = 4'd9; ra2 = 4'd0; ra3 = 4'd3;
    @(negedge g_clk);
    chk("load_busy", 32'(busy0), 32'h0004);
    chk("load_rd9", ifs[0].crs1_rdata, 32'h0A0A0A0A);
    chk("idle_clk_req", 32'(ck0), 32'h0);
    @(posedge g_clk);
    #1 zero_req = 1'b1;
    #1 chk("zreq_clk_req", 32'(ck0), 32'h1);
    @(posedge g_clk);
    #1 zero_req = 1'b0;

    nbusy = 0; ndone = 0; done_at = 0; bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge g_clk);
      if (!zb0) break;
      nbusy++;
      if (zd0) begin
        ndone++;
        done_at = nbusy;
      end
      if (ifs[0].crs1_rdata != 0 || ifs[0].crs2_rdata != 0 ||
          ifs[0].crs3_rdata != 0) bad++;
      @(posedge g_clk);
      #1 idle_in();
      if (nbusy == 3) begin
        wa = 4'hF; aa = 4'd0; da = 32'hFFFFFFFF;
      end
      if (nbusy == 6) zero_req = 1'b1;
    end
    chk("zero_busy_cycles", nbusy, 17);
    chk("zero_done_pulses", ndone, 1);
    chk("zero_done_cycle", done_at, 17);
    chk("zero_reads_gated", bad, 0);
    chk("post_zero_busy", 32'(busy0), 32'h0);
    chk("post_zero_done", 32'(zd0), 32'h0);
    nz = 0;
    for (int i = 0; i < 16; i++) begin
      ra1 = 4'(i);
      #1;
      if (ifs[0].crs1_rdata != 0) nz++;
    end
    chk("post_zero_regs", nz, 0);

    // Reset in the middle of a wipe
    @(posedge g_clk);
    #1 idle_in();
    wa = 4'hF; aa = 4'd10; da = 32'h5A5A5A5A;
    sb_set = 1'b1; sb_addr = 4'd2;
    @(posedge g_clk);
    #1 idle_in();
    ra1 = 4'd10;
    zero_req = 1'b1;
    #1 r5 = ifs[0].crs1_rdata;
    chk("pre_wipe_rd10", r5, 32'h5A5A5A5A);
    @(posedge g_clk);
    #1 zero_req = 1'b0;
    repeat (6) @(posedge g_clk);
    #1 chk("wipe_active", 32'(zb0), 32'h1);
    g_resetn = 1'b0;
    @(posedge g_clk);
    #1 g_resetn = 1'b1;
    @(negedge g_clk);
    chk("rst_mid_zero_busy", 32'(zb0), 32'h0);
    chk("rst_mid_busy", 32'(busy0), 32'h0);
    chk("rst_mid_rd10", ifs[0].crs1_rdata, 32'h0);
    ndone = 0; nzb = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge g_clk);
      if (zd0) ndone++;
      if (zb0) nzb++;
    end
    chk("rst_mid_no_done", ndone, 0);
    chk("rst_mid_stays_idle", nzb, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
